// File: rtl/sbox_layer_seq.sv
// Sequential ASCON substitution layer p_S over the full 320-bit state.
// SBOX_PAR 5-bit S-box lanes are applied per clock, walking the 64 columns
// from column 0 upwards, so a layer takes 64/SBOX_PAR RUN cycles.
// Column j is {x0[j],x1[j],x2[j],x3[j],x4[j]} with x0[j] as the MSB.
//
// Ports:
//   clock_i  system clock, rising edge
//   reset_i  synchronous, active-high reset
//   start_i  process state_i; accepted only while ready_o is high
//   inv_i    0: forward S-box, 1: inverse S-box; sampled with an accepted start
//   state_i  input state, [319:256]=x0 ... [63:0]=x4
//   state_o  working register (valid from done_o until the next accepted start)
//   ready_o  high in IDLE
//   busy_o   high in RUN
//   done_o   one-cycle pulse once state_o holds the complete result
module sbox_layer_seq #(
  parameter int unsigned SBOX_PAR = 8
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         start_i,
  input  logic         inv_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam int unsigned NB_CYCLES = 64 / SBOX_PAR;
  localparam int unsigned CntW      = (NB_CYCLES > 1) ? $clog2(NB_CYCLES) : 1;
  localparam int unsigned ParLog2   = $clog2(SBOX_PAR);
  localparam logic [CntW-1:0] CntLast = CntW'(NB_CYCLES - 1);

  if (SBOX_PAR != 1 && SBOX_PAR != 2 && SBOX_PAR != 4 && SBOX_PAR != 8 &&
      SBOX_PAR != 16 && SBOX_PAR != 32 && SBOX_PAR != 64) begin : gen_bad_par
    $error("sbox_layer_seq: SBOX_PAR must be one of 1,2,4,8,16,32,64");
  end

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e            st_q, st_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              mode_q, mode_d;
  // Packed as five 64-bit lanes: work_q[4] = x0 ... work_q[0] = x4.
  logic [4:0][63:0]  work_q, work_d;
  logic [4:0][63:0]  work_sub;
  logic [5:0]        base;
  logic [5:0]        idx;
  logic [4:0]        col;
  logic [4:0]        sub;

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    logic [4:0] y;
    unique case (x)
      5'h00: y = 5'h04;  5'h01: y = 5'h0B;  5'h02: y = 5'h1F;  5'h03: y = 5'h14;
      5'h04: y = 5'h1A;  5'h05: y = 5'h15;  5'h06: y = 5'h09;  5'h07: y = 5'h02;
      5'h08: y = 5'h1B;  5'h09: y = 5'h05;  5'h0A: y = 5'h08;  5'h0B: y = 5'h12;
      5'h0C: y = 5'h1D;  5'h0D: y = 5'h03;  5'h0E: y = 5'h06;  5'h0F: y = 5'h1C;
      5'h10: y = 5'h1E;  5'h11: y = 5'h13;  5'h12: y = 5'h07;  5'h13: y = 5'h0E;
      5'h14: y = 5'h00;  5'h15: y = 5'h0D;  5'h16: y = 5'h11;  5'h17: y = 5'h18;
      5'h18: y = 5'h10;  5'h19: y = 5'h0C;  5'h1A: y = 5'h01;  5'h1B: y = 5'h19;
      5'h1C: y = 5'h16;  5'h1D: y = 5'h0A;  5'h1E: y = 5'h0F;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    logic [4:0] y;
    unique case (x)
      5'h00: y = 5'h14;  5'h01: y = 5'h1A;  5'h02: y = 5'h07;  5'h03: y = 5'h0D;
      5'h04: y = 5'h00;  5'h05: y = 5'h09;  5'h06: y = 5'h0E;  5'h07: y = 5'h12;
      5'h08: y = 5'h0A;  5'h09: y = 5'h06;  5'h0A: y = 5'h1D;  5'h0B: y = 5'h01;
      5'h0C: y = 5'h19;  5'h0D: y = 5'h15;  5'h0E: y = 5'h13;  5'h0F: y = 5'h1E;
      5'h10: y = 5'h18;  5'h11: y = 5'h16;  5'h12: y = 5'h0B;  5'h13: y = 5'h11;
      5'h14: y = 5'h03;  5'h15: y = 5'h05;  5'h16: y = 5'h1C;  5'h17: y = 5'h1F;
      5'h18: y = 5'h17;  5'h19: y = 5'h1B;  5'h1A: y = 5'h04;  5'h1B: y = 5'h08;
      5'h1C: y = 5'h0F;  5'h1D: y = 5'h0C;  5'h1E: y = 5'h10;  default: y = 5'h02;
    endcase
    return y;
  endfunction

  // Substitute the current column group in place; all other columns pass through.
  always_comb begin
    work_sub = work_q;
    base     = 6'(cnt_q) << ParLog2;
    idx      = '0;
    col      = '0;
    sub      = '0;
    for (int k = 0; k < SBOX_PAR; k++) begin
      idx = base + 6'(k);
      for (int l = 0; l < 5; l++) begin
        col[l] = work_q[l][idx];
      end
      sub = mode_q ? sbox_inv(col) : sbox_fwd(col);
      for (int l = 0; l < 5; l++) begin
        work_sub[l][idx] = sub[l];
      end
    end
  end

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    mode_d = mode_q;
    work_d = work_q;
    unique case (st_q)
      StIdle: begin
        if (start_i) begin
          work_d = state_i;
          mode_d = inv_i;
          cnt_d  = '0;
          st_d   = StRun;
        end
      end
      StRun: begin
        work_d = work_sub;
        // cnt holds at its last value rather than wrapping; start clears it.
        if (cnt_q == CntLast) begin
          st_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        st_d = StIdle;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      st_q   <= StIdle;
      cnt_q  <= '0;
      mode_q <= 1'b0;
      work_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      work_q <= work_d;
    end
  end

  assign state_o = work_q;
  assign ready_o = (st_q == StIdle);
  assign busy_o  = (st_q == StRun);
  assign done_o  = (st_q == StDone);

endmodule

// File: tb/tb_sbox_layer_seq.sv
// Directed bench for sbox_layer_seq at SBOX_PAR = 1, 8 and 64.
// Expected states are queued when an operation is launched and compared
// against state_o when done_o is seen.
module tb_sbox_layer_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start;
  logic         inv;
  logic [319:0] st_in;
  logic [319:0] so  [3];
  logic         rdy [3];
  logic         bsy [3];
  logic         dn  [3];

  sbox_layer_seq #(.SBOX_PAR(1)) u_p1 (
    .clock_i(clk), .reset_i(rst), .start_i(start[0]), .inv_i(inv), .state_i(st_in),
    .state_o(so[0]), .ready_o(rdy[0]), .busy_o(bsy[0]), .done_o(dn[0])
  );
  sbox_layer_seq #(.SBOX_PAR(8)) u_p8 (
    .clock_i(clk), .reset_i(rst), .start_i(start[1]), .inv_i(inv), .state_i(st_in),
    .state_o(so[1]), .ready_o(rdy[1]), .busy_o(bsy[1]), .done_o(dn[1])
  );
  sbox_layer_seq #(.SBOX_PAR(64)) u_p64 (
    .clock_i(clk), .reset_i(rst), .start_i(start[2]), .inv_i(inv), .state_i(st_in),
    .state_o(so[2]), .ready_o(rdy[2]), .busy_o(bsy[2]), .done_o(dn[2])
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [319:0] sb_q [$];
  logic [4:0] fwd_t [32];
  logic [4:0] inv_t [32];
  int lat_exp [3] = '{65, 9, 2};

  function automatic logic [319:0] model(input logic [319:0] s, input logic m);
    logic [319:0] r;
    logic [4:0] c, y;
    r = s;
    for (int j = 0; j < 64; j++) begin
      c = {s[256+j], s[192+j], s[128+j], s[64+j], s[j]};
      y = m ? inv_t[c] : fwd_t[c];
      r[256+j] = y[4]; r[192+j] = y[3]; r[128+j] = y[2]; r[64+j] = y[1]; r[j] = y[0];
    end
    return r;
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check_s(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_b(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic check_i(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one start pulse; returns just after the accepting edge.
  task automatic launch(input int u, input logic m, input logic [319:0] s,
                        input logic [319:0] exp);
    inv      = m;
    st_in    = s;
    start[u] = 1'b1;
    sb_q.push_back(exp);
    tick();
    start[u] = 1'b0;
  endtask

  // Called just after the accepting edge. Checks handshake outputs each cycle,
  // latency, the queued result, and the return to IDLE one cycle after done_o.
  task automatic wait_done(input int u, input int exp_lat);
    int lat;
    logic [319:0] exp;
    lat = 1;
    while (dn[u] !== 1'b1 && lat < 300) begin
      check_b("run_busy", bsy[u], 1'b1);
      check_b("run_ready", rdy[u], 1'b0);
      tick();
      lat++;
    end
    check_b("done_seen", dn[u], 1'b1);
    check_b("done_ready", rdy[u], 1'b0);
    check_b("done_busy", bsy[u], 1'b0);
    check_i("latency", lat, exp_lat);
    if (sb_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected an entry");
    end else begin
      exp = sb_q.pop_front();
      check_s("result", so[u], exp);
    end
    tick();
    check_b("post_ready", rdy[u], 1'b1);
    check_b("post_busy", bsy[u], 1'b0);
    check_b("post_done", dn[u], 1'b0);
  endtask

  initial begin
    logic [319:0] p, fp, a, b, c, ones_exp;
    int pulses;

    fwd_t = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
              5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
              5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
              5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};
    for (int x = 0; x < 32; x++) inv_t[fwd_t[x]] = 5'(x);

    rst   = 1'b1;
    start = '0;
    inv   = 1'b0;
    st_in = '0;
    tick();
    tick();
    for (int u = 0; u < 3; u++) begin
      check_b("rst_ready", rdy[u], 1'b1);
      check_b("rst_busy", bsy[u], 1'b0);
      check_b("rst_done", dn[u], 1'b0);
      check_s("rst_state", so[u], '0);
    end
    rst = 1'b0;
    tick();

    // All-zero state: every column 00 -> 04, i.e. only x2 set.
    launch(1, 1'b0, '0, {64'h0, 64'h0, {64{1'b1}}, 64'h0, 64'h0});
    wait_done(1, 9);

    // All-ones state: every column 1F -> 17, i.e. only x1 cleared.
    ones_exp = {{64{1'b1}}, 64'h0, {64{1'b1}}, {64{1'b1}}, {64{1'b1}}};
    launch(1, 1'b0, {320{1'b1}}, ones_exp);
    wait_done(1, 9);
    tick();
    tick();
    tick();
    check_s("hold_after_done", so[1], ones_exp);

    // Column j = j mod 32, forward then inverse, at every parallelism.
    for (int j = 0; j < 64; j++) begin
      logic [4:0] v;
      v = 5'(j % 32);
      p[256+j] = v[4]; p[192+j] = v[3]; p[128+j] = v[2]; p[64+j] = v[1]; p[j] = v[0];
    end
    fp = model(p, 1'b0);
    for (int u = 0; u < 3; u++) begin
      launch(u, 1'b0, p, fp);
      wait_done(u, lat_exp[u]);
      launch(u, 1'b1, fp, p);
      wait_done(u, lat_exp[u]);
    end

    // Start held high through RUN and DONE with a changed state_i.
    a = rand320();
    b = rand320();
    inv      = 1'b0;
    st_in    = a;
    start[1] = 1'b1;
    sb_q.push_back(model(a, 1'b0));
    tick();
    st_in = b;
    wait_done(1, 9);
    sb_q.push_back(model(b, 1'b0));
    tick();
    check_b("held_accept_busy", bsy[1], 1'b1);
    start[1] = 1'b0;
    wait_done(1, 9);

    // Reset during the 4th RUN cycle aborts without a done pulse.
    c = rand320();
    inv      = 1'b0;
    st_in    = c;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    tick();
    tick();
    tick();
    check_b("pre_rst_busy", bsy[1], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_b("abort_ready", rdy[1], 1'b1);
    check_b("abort_busy", bsy[1], 1'b0);
    check_b("abort_done", dn[1], 1'b0);
    check_s("abort_state", so[1], '0);
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (dn[1] === 1'b1) pulses++;
    end
    check_i("abort_no_done", pulses, 0);
    c = rand320();
    launch(1, 1'b0, c, model(c, 1'b0));
    wait_done(1, 9);

    // Inverse of 04 in every column is 00.
    launch(1, 1'b1, {64'h0, 64'h0, {64{1'b1}}, 64'h0, 64'h0}, '0);
    wait_done(1, 9);

    // Random inverse operation on the fully parallel instance.
    c = rand320();
    launch(2, 1'b1, c, model(c, 1'b1));
    wait_done(2, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
